// File: rtl/mem_ram_arbiter.sv
// Two-requester arbiter for the single-port data RAM: IF (read-only) and LS (read/masked write).
// Define ARB_FIXED_PRIO_EN for strict LS priority; default build is round-robin.
module mem_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  ls_req_i,
   input  logic [ADDR_WIDTH-1:0] ls_addr_i,
   input  logic [DATA_WIDTH-1:0] ls_wdata_i,
   input  logic [3:0]            ls_wmask_i,
   output logic                  ls_gnt_o,
   output logic                  ls_rvalid_o,
   output logic [DATA_WIDTH-1:0] ls_rdata_o,
   output logic                  ram_en_n_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic [3:0]            ram_wmask_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RESP
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wmask_q, wmask_d;
   logic                  en_n_q, en_n_d;
   logic                  if_gnt_q, if_gnt_d;
   logic                  ls_gnt_q, ls_gnt_d;
   logic                  if_rvalid_q, if_rvalid_d;
   logic                  ls_rvalid_q, ls_rvalid_d;
   logic                  pick_ls;
`ifndef ARB_FIXED_PRIO_EN
   logic                  last_ls_q, last_ls_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         en_n_q      <= 1'b1;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         last_ls_q   <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         en_n_q      <= en_n_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
`ifndef ARB_FIXED_PRIO_EN
         last_ls_q   <= last_ls_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = '0;
      en_n_d      = 1'b1;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      pick_ls     = ls_req_i;
`else
      last_ls_d   = last_ls_q;
      pick_ls     = ls_req_i && (!if_req_i || !last_ls_q);
`endif
      case (state_q)
         // In ISSUE the registered mask and grants still describe the command in flight.
         ST_ISSUE: begin
            if (wmask_q == '0) begin
               state_d     = ST_RESP;
               if_rvalid_d = if_gnt_q;
               ls_rvalid_d = ls_gnt_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (if_req_i || ls_req_i) begin
               state_d = ST_ISSUE;
               en_n_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
               last_ls_d = pick_ls;
`endif
               if (pick_ls) begin
                  addr_d   = ls_addr_i;
                  wdata_d  = ls_wdata_i;
                  wmask_d  = ls_wmask_i;
                  ls_gnt_d = 1'b1;
               end else begin
                  addr_d   = if_addr_i;
                  if_gnt_d = 1'b1;
               end
            end
         end
      endcase
   end

   assign if_gnt_o    = if_gnt_q;
   assign ls_gnt_o    = ls_gnt_q;
   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_rdata_o  = if_rvalid_q ? ram_rdata_i : '0;
   assign ls_rdata_o  = ls_rvalid_q ? ram_rdata_i : '0;
   assign ram_en_n_o  = en_n_q;
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;
   assign ram_wmask_o = wmask_q;

endmodule

// File: tb/tb_mem_ram_arbiter.sv
// Bench for mem_ram_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with reset pulses.
module tb_mem_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i = 1'b0;
   logic [31:0] ls_addr_i = '0;
   logic [31:0] ls_wdata_i = '0;
   logic [3:0]  ls_wmask_i = '0;
   logic        ls_gnt_o, ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        ram_en_n_o;
   logic [31:0] ram_addr_o, ram_wdata_o;
   logic [3:0]  ram_wmask_o;
   logic [31:0] ram_rdata_i = '0;

   int tests = 0;
   int fails = 0;
   bit rand_mode = 1'b0;

   mem_ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
      .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
      .ls_rdata_o(ls_rdata_o), .ram_en_n_o(ram_en_n_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] w;
      w = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
      if (i == 16) w = 32'hDEAD_BEEF;
      if (i == 32) w = 32'h1122_3344;
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Environment RAM: one-cycle read latency, byte-masked writes.
   logic [31:0] ram [64];
   initial begin
      for (int i = 0; i < 64; i++) ram[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (!ram_en_n_o) begin
            if (ram_wmask_o == 4'b0000) ram_rdata_i = ram[ram_addr_o[5:0]];
            else
               for (int b = 0; b < 4; b++)
                  if (ram_wmask_o[b]) ram[ram_addr_o[5:0]][8*b +: 8] = ram_wdata_o[8*b +: 8];
         end
      end
   end

   // Reference model: an accept at edge e grants in the following cycle, returns read
   // data one cycle later, and the next accept may happen no earlier than edge e+2.
   logic [31:0] refmem [64];
   int          edge_n = 0;
   int          free_edge = 0;
   bit          last_ls = 1'b1;
   bit          pend_if = 1'b0, pend_ls = 1'b0;
   logic [31:0] pend_data = '0;
   bit          mvalid = 1'b0;
   bit          x_en_n, x_ifg, x_lsg, x_ifrv, x_lsrv, x_chk_wd;
   logic [31:0] x_addr, x_wdata, x_rdata;
   logic [3:0]  x_mask;

   initial begin
      bit pick;
      logic [5:0] a;
      for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
      x_addr = '0; x_wdata = '0;
      forever begin
         @(posedge clk);
         edge_n++;
         x_en_n = 1'b1; x_mask = '0; x_ifg = 1'b0; x_lsg = 1'b0; x_chk_wd = 1'b0;
         if (reset) begin
            x_ifrv = 1'b0; x_lsrv = 1'b0; x_rdata = '0;
            x_addr = '0; x_wdata = '0; x_chk_wd = 1'b1;
            pend_if = 1'b0; pend_ls = 1'b0;
            free_edge = edge_n + 1; last_ls = 1'b1;
         end else begin
            x_ifrv = pend_if; x_lsrv = pend_ls; x_rdata = pend_data;
            pend_if = 1'b0; pend_ls = 1'b0;
            if (edge_n >= free_edge && (if_req_i || ls_req_i)) begin
`ifdef ARB_FIXED_PRIO_EN
               pick = ls_req_i;
`else
               pick = ls_req_i && (!if_req_i || !last_ls);
`endif
               last_ls = pick;
               free_edge = edge_n + 2;
               x_en_n = 1'b0;
               if (pick) begin
                  x_lsg = 1'b1; x_addr = ls_addr_i; x_mask = ls_wmask_i;
                  a = ls_addr_i[5:0];
                  if (ls_wmask_i != 4'b0000) begin
                     x_wdata = ls_wdata_i; x_chk_wd = 1'b1;
                     for (int b = 0; b < 4; b++)
                        if (ls_wmask_i[b]) refmem[a][8*b +: 8] = ls_wdata_i[8*b +: 8];
                  end else begin
                     pend_ls = 1'b1; pend_data = refmem[a];
                  end
               end else begin
                  x_ifg = 1'b1; x_addr = if_addr_i;
                  pend_if = 1'b1; pend_data = refmem[if_addr_i[5:0]];
               end
            end
         end
         mvalid = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("en_n", 32'(ram_en_n_o), 32'(x_en_n));
         chk("ram_wmask", 32'(ram_wmask_o), 32'(x_mask));
         chk("ram_addr", ram_addr_o, x_addr);
         if (x_chk_wd) chk("ram_wdata", ram_wdata_o, x_wdata);
         chk("if_gnt", 32'(if_gnt_o), 32'(x_ifg));
         chk("ls_gnt", 32'(ls_gnt_o), 32'(x_lsg));
         chk("if_rvalid", 32'(if_rvalid_o), 32'(x_ifrv));
         chk("ls_rvalid", 32'(ls_rvalid_o), 32'(x_lsrv));
         chk("if_rdata", if_rdata_o, x_ifrv ? x_rdata : 32'h0);
         chk("ls_rdata", ls_rdata_o, x_lsrv ? x_rdata : 32'h0);
      end
   end

   // Random requesters: hold a request until granted, then pick a new one.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            if (if_gnt_o || !if_req_i) begin
               if_req_i  = ($urandom_range(0, 2) != 0);
               if_addr_i = 32'($urandom_range(0, 63));
            end
            if (ls_gnt_o || !ls_req_i) begin
               ls_req_i   = ($urandom_range(0, 2) != 0);
               ls_addr_i  = 32'($urandom_range(0, 63));
               ls_wdata_i = $urandom;
               ls_wmask_i = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 99) == 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int gcount;
      logic [3:0] gseq;
      logic [3:0] gexp;
      // Reset held with both requests up, then IF wins the first tie.
      if_req_i = 1'b1; if_addr_i = 32'h10;
      ls_req_i = 1'b1; ls_addr_i = 32'h20; ls_wmask_i = 4'b0000;
      tick();
      chk("rst1_en_n", 32'(ram_en_n_o), 32'd1);
      chk("rst1_gnt", 32'({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o}), 32'd0);
      tick();
      chk("rst2_mask", 32'(ram_wmask_o), 32'd0);
      chk("rst2_addr", ram_addr_o, 32'd0);
      reset = 1'b0;
      tick();
      chk("first_tie_if", 32'({if_gnt_o, ls_gnt_o}), 32'b10);
      if_req_i = 1'b0; ls_req_i = 1'b0;
      tick(); tick();

      // IF read of 0x10.
      if_req_i = 1'b1; if_addr_i = 32'h10;
      tick();
      chk("if_rd_gnt", 32'(if_gnt_o), 32'd1);
      chk("if_rd_en", 32'(ram_en_n_o), 32'd0);
      chk("if_rd_addr", ram_addr_o, 32'h10);
      if_req_i = 1'b0;
      tick();
      chk("if_rd_rvalid", 32'(if_rvalid_o), 32'd1);
      chk("if_rd_data", if_rdata_o, 32'hDEADBEEF);
      tick();

      // LS masked write then read back.
      ls_req_i = 1'b1; ls_addr_i = 32'h20; ls_wdata_i = 32'hAABBCCDD; ls_wmask_i = 4'b0011;
      tick();
      chk("ls_wr_gnt", 32'(ls_gnt_o), 32'd1);
      chk("ls_wr_mask", 32'(ram_wmask_o), 32'b0011);
      ls_wmask_i = 4'b0000;
      tick();
      chk("ls_wr_norv", 32'(ls_rvalid_o), 32'd0);
      tick();
      chk("ls_rd_gnt", 32'(ls_gnt_o), 32'd1);
      ls_req_i = 1'b0;
      tick();
      chk("ls_rd_rvalid", 32'(ls_rvalid_o), 32'd1);
      chk("ls_rd_data", ls_rdata_o, 32'h1122CCDD);
      tick();

      // Back-to-back: LS request raised during IF's response cycle.
      if_req_i = 1'b1; if_addr_i = 32'h10;
      tick();
      if_req_i = 1'b0;
      tick();
      chk("b2b_if_rv", 32'(if_rvalid_o), 32'd1);
      ls_req_i = 1'b1; ls_addr_i = 32'h20; ls_wmask_i = 4'b0000;
      tick();
      chk("b2b_ls_gnt", 32'(ls_gnt_o), 32'd1);
      ls_req_i = 1'b0;
      tick();
      chk("b2b_ls_rv", 32'(ls_rvalid_o), 32'd1);
      chk("b2b_ls_data", ls_rdata_o, 32'h1122CCDD);

      // Both requesting continuously.
      if_req_i = 1'b1; ls_req_i = 1'b1;
      gcount = 0; gseq = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (if_gnt_o || ls_gnt_o) begin
            if (gcount < 4) gseq[gcount] = ls_gnt_o;
            gcount++;
         end
      end
      if_req_i = 1'b0; ls_req_i = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      gexp = 4'b1111;
`else
      gexp = 4'b1010;
`endif
      chk("tie_count", 32'(gcount), 32'd4);
      chk("tie_order", 32'(gseq), 32'(gexp));
      tick(); tick();

      // Reset during ISSUE of an IF read.
      if_req_i = 1'b1; if_addr_i = 32'h5;
      tick();
      chk("abort_gnt", 32'(if_gnt_o), 32'd1);
      reset = 1'b1; if_req_i = 1'b0;
      tick();
      chk("abort_en", 32'(ram_en_n_o), 32'd1);
      chk("abort_rv", 32'(if_rvalid_o), 32'd0);
      reset = 1'b0;
      tick();
      chk("abort_rv2", 32'(if_rvalid_o), 32'd0);

      // Randomized traffic.
      rand_mode = 1'b1;
      repeat (4000) @(posedge clk);
      rand_mode = 1'b0;
      #1;
      if_req_i = 1'b0; ls_req_i = 1'b0; reset = 1'b0;
      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
